// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle processor control sequencer
// Steps each instruction through its stages and drives per-stage datapath enables.
module multicycle_sequencer #(
  parameter int COUNT_WIDTH = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Run,
  input  logic                   Halt,
  input  logic [1:0]             InstrClass,
  input  logic                   BranchTaken,
  input  logic                   MemReady,
  output logic [2:0]             Stage,
  output logic                   IrWrite,
  output logic                   PcWrite,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   AluEnable,
  output logic                   RegWrite,
  output logic                   InstrDone,
  output logic [COUNT_WIDTH-1:0] InstrCount,
  output logic                   Fault
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_FAULT     = 3'd7
  } state_t;

  localparam logic [1:0] C_ALU    = 2'd0;
  localparam logic [1:0] C_LOAD   = 2'd1;
  localparam logic [1:0] C_STORE  = 2'd2;
  localparam logic [1:0] C_BRANCH = 2'd3;
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [1:0]             class_q, class_d;
  logic [7:0]             wait_q, wait_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   retire;

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    wait_d    = '0;
    count_d   = count_q;
    retire    = 1'b0;
    IrWrite   = 1'b0;
    PcWrite   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    AluEnable = 1'b0;
    RegWrite  = 1'b0;
    InstrDone = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Run) state_d = S_FETCH;
      end
      S_FETCH: begin
        MemRead = 1'b1;
        IrWrite = MemReady;
        PcWrite = MemReady;
        if (MemReady) state_d = S_DECODE;
        else if (wait_q == WAIT_LIMIT) state_d = S_FAULT;
        else wait_d = wait_q + 8'd1;
      end
      S_DECODE: begin
        class_d = InstrClass;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        AluEnable = 1'b1;
        case (class_q)
          C_ALU:           state_d = S_WRITEBACK;
          C_LOAD, C_STORE: state_d = S_MEMORY;
          default: begin
            PcWrite = BranchTaken;
            retire  = 1'b1;
          end
        endcase
      end
      S_MEMORY: begin
        MemRead  = (class_q == C_LOAD);
        MemWrite = (class_q == C_STORE);
        if (MemReady) begin
          if (class_q == C_LOAD) state_d = S_WRITEBACK;
          else retire = 1'b1;
        end else if (wait_q == WAIT_LIMIT) state_d = S_FAULT;
        else wait_d = wait_q + 8'd1;
      end
      S_WRITEBACK: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    // Retirement overrides the stage's own next state; Halt picks idle vs. next fetch.
    if (retire) begin
      InstrDone = 1'b1;
      count_d   = count_q + COUNT_WIDTH'(1);
      state_d   = Halt ? S_IDLE : S_FETCH;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      class_q <= '0;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  assign Stage      = state_q;
  assign Fault      = (state_q == S_FAULT);
  assign InstrCount = count_q;

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Control sequencer for the multi-cycle processor. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK and skips stages the instruction class does not need.
- It holds in FETCH and MEMORY until the memory handshake completes, and drives the per-stage datapath enables.
- It reports the current stage using the team's 1..5 stage numbering and counts retired instructions.

Parameters:
- COUNT_WIDTH, 16, width of the retired-instruction counter InstrCount.
- MEM_TIMEOUT, 15, maximum consecutive wait cycles (MemReady low) tolerated in FETCH or MEMORY before FAULT. Legal range 1..255.

Ports:
- Clock  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Run  input  1  start request; sampled only in IDLE.
- Halt  input  1  stop request; sampled only at instruction retirement.
- InstrClass  input  2  class from decoder, valid in DECODE: 0=ALU, 1=LOAD, 2=STORE, 3=BRANCH.
- BranchTaken  input  1  ALU branch condition; valid in EXECUTE.
- MemReady  input  1  memory completes the current access this cycle.
- Stage  output  3  0=IDLE, 1=FETCH, 2=DECODE, 3=EXECUTE, 4=MEMORY, 5=WRITEBACK, 7=FAULT.
- IrWrite  output  1  load instruction register.
- PcWrite  output  1  update PC.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- AluEnable  output  1  ALU operand and result registers enabled.
- RegWrite  output  1  register file write.
- InstrDone  output  1  one-cycle pulse on the retiring cycle.
- InstrCount  output  COUNT_WIDTH  retired instructions; wraps modulo 2^COUNT_WIDTH.
- Fault  output  1  high while in FAULT.

Behaviour:
- Reset, taking priority over every other input, forces the following on the next edge:
  - Stage=0 (IDLE); internal state cleared.
  - InstrCount=0, latched class=0, wait counter=0.
  - All enables and InstrDone low; Fault low.
- Reset asserted mid-instruction abandons it. It is not counted and no enable fires.
- Stage is the state register. Registers: state, latched class, wait counter, InstrCount.
- Enables are decoded combinationally from state, latched class and inputs:
  - FETCH: MemRead=1. IrWrite=PcWrite=MemReady.
  - DECODE: InstrClass is latched into the class register at the end of the cycle. No enables.
  - EXECUTE: AluEnable=1. PcWrite=BranchTaken when the latched class is BRANCH, otherwise 0.
  - MEMORY: MemRead=1 for LOAD, MemWrite=1 for STORE. Both are held until MemReady.
  - WRITEBACK: RegWrite=1.
- State transitions:
  - IDLE: Run=1 -> FETCH; else stay.
  - FETCH: MemReady=1 -> DECODE; else stay.
  - DECODE: -> EXECUTE, always one cycle.
  - EXECUTE:
    - ALU -> WRITEBACK.
    - LOAD or STORE -> MEMORY.
    - BRANCH retires here.
  - MEMORY, waiting until MemReady=1:
    - LOAD -> WRITEBACK.
    - STORE retires here.
  - WRITEBACK: retires; one cycle.
- Minimum stage sequences with MemReady always high:
  - ALU: 1,2,3,5 (4 cycles).
  - LOAD: 1,2,3,4,5 (5 cycles).
  - STORE: 1,2,3,4 (4 cycles).
  - BRANCH: 1,2,3 (3 cycles).
- Retirement cycle:
  - InstrDone=1.
  - InstrCount increments at the edge ending the cycle.
  - Next state is IDLE if Halt=1, else FETCH.
  - Run is ignored outside IDLE.
- Wait counter:
  - Cleared on every entry to FETCH or MEMORY.
  - Increments each cycle spent in FETCH or MEMORY with MemReady=0.
  - If MemReady=0 and the counter equals MEM_TIMEOUT-1, the next state is FAULT. The stage therefore tolerates exactly MEM_TIMEOUT wait cycles.
  - MemReady=1 on the same cycle as the limit wins: normal transition.
- FAULT: all enables low, Fault=1, Stage=7. Reset is the only exit; Run and Halt are ignored.
- MemReady outside FETCH and MEMORY is ignored.
- InstrClass outside DECODE is ignored. Changing it after DECODE has no effect.
- InstrCount at its all-ones value plus one retirement wraps to 0, with no flag.

Test Plan:
- Reset, then Run=0 for 5 cycles -> Stage=0, InstrCount=0, all enables 0, Fault=0 throughout.
- Run=1 for one cycle, MemReady=1, InstrClass=ALU, Halt=1 -> Stage 1,2,3,5,0; IrWrite/PcWrite in stage 1; RegWrite in stage 5; InstrDone once; InstrCount=1.
- LOAD with MemReady low for 2 cycles in MEMORY, Halt=0 -> Stage 1,2,3,4,4,4,5,1; MemRead high all three MEMORY cycles; RegWrite once.
- BRANCH with BranchTaken=1, then STORE -> branch: PcWrite in stage 3, retires after 3 cycles. Store: MemWrite in stage 4, no RegWrite, retires after 4 cycles; InstrCount=2.
- MEM_TIMEOUT=3 with MemReady held 0 in FETCH -> Stage=1 for 3 cycles, then 7, Fault=1. Run/Halt toggling has no effect; Reset returns Stage=0.
- Reset asserted during MEMORY of a LOAD -> next cycle Stage=0, InstrCount unchanged from 0, no RegWrite or InstrDone.
- COUNT_WIDTH=2, 4 ALU instructions -> InstrCount 1,2,3,0.
